// File: rtl/mem_store_buffer_pkg.sv
// Shared types and store opcodes for the MEM-stage store buffer.
// Store codes sit alongside the load-extender codes used elsewhere in MEM.
package mem_store_buffer_pkg;

  localparam logic [2:0] MS_SW = 3'b000;
  localparam logic [2:0] MS_SH = 3'b001;
  localparam logic [2:0] MS_SB = 3'b010;

  typedef struct packed {
    logic [29:0] waddr;
    logic [31:0] data;
    logic [3:0]  be;
  } sb_entry_t;

endpackage

// File: rtl/mem_store_buffer_aligner.sv
// Store aligner: maps SW/SH/SB onto byte lanes, builds byte enables and
// classifies misaligned or illegal opcodes. Purely combinational.
module mem_store_buffer_aligner
  import mem_store_buffer_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] data_i,
  output logic [3:0]  be_o,
  output logic [31:0] data_o,
  output logic        misalign_o,
  output logic        illegal_o
);

  always_comb begin
    be_o       = 4'b0000;
    data_o     = 32'h0;
    misalign_o = 1'b0;
    illegal_o  = 1'b0;
    case (op_i)
      MS_SW: begin
        be_o       = 4'b1111;
        data_o     = data_i;
        misalign_o = (addr_lo_i != 2'b00);
      end
      MS_SH: begin
        be_o       = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        data_o     = {2{data_i[15:0]}};
        misalign_o = addr_lo_i[0];
      end
      MS_SB: begin
        be_o   = 4'b0001 << addr_lo_i;
        data_o = {4{data_i[7:0]}};
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_store_buffer.sv
// Store buffer: aligns MEM-stage stores, coalesces into the youngest entry,
// and drains the head entry to data memory over req/ack.
module mem_store_buffer
  import mem_store_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [2:0]  st_op,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        misalign,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] ld_addr,
  output logic        ld_hit,
  output logic        empty
);

  localparam int PW = $clog2(DEPTH);

  sb_entry_t       ent_q [DEPTH];
  sb_entry_t       ent_d [DEPTH];
  sb_entry_t       head_ent;
  logic [PW-1:0]   head_q, head_d, tail_q, tail_d, tail_m1;
  logic [PW:0]     count_q, count_d;
  logic            misalign_q, misalign_d;

  logic [3:0]      al_be;
  logic [31:0]     al_data;
  logic            al_mis, al_ill;
  logic            full, accept, enq_ok, merge, push, pop;
  logic [31:0]     merged_data;
  logic            unused_ld;

  mem_store_buffer_aligner u_aligner (
    .op_i       (st_op),
    .addr_lo_i  (st_addr[1:0]),
    .data_i     (st_data),
    .be_o       (al_be),
    .data_o     (al_data),
    .misalign_o (al_mis),
    .illegal_o  (al_ill)
  );

  assign unused_ld = ^ld_addr[1:0];

  assign empty    = (count_q == '0);
  assign full     = (count_q == (PW+1)'(DEPTH));
  assign st_ready = !full;
  assign accept   = st_valid && st_ready;
  assign enq_ok   = accept && !al_mis && !al_ill;
  assign tail_m1  = tail_q - PW'(1);

  // With two or more entries tail-1 is never the head, so merging cannot disturb the bus.
  assign merge = enq_ok && (count_q >= (PW+1)'(2)) && (ent_q[tail_m1].waddr == st_addr[31:2]);
  assign push  = enq_ok && !merge;
  assign pop   = mem_req && mem_ack;

  assign head_ent  = ent_q[head_q];
  assign mem_req   = !empty;
  assign mem_addr  = {head_ent.waddr, 2'b00};
  assign mem_wdata = head_ent.data;
  assign mem_be    = head_ent.be;
  assign misalign  = misalign_q;

  always_comb begin
    merged_data = ent_q[tail_m1].data;
    for (int b = 0; b < 4; b++) begin
      if (al_be[b]) merged_data[8*b +: 8] = al_data[8*b +: 8];
    end
  end

  // Popped slots are cleared so an empty buffer presents all-zero head outputs.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) ent_d[i] = ent_q[i];
    if (pop) ent_d[head_q] = '0;
    if (push) begin
      ent_d[tail_q].waddr = st_addr[31:2];
      ent_d[tail_q].data  = al_data;
      ent_d[tail_q].be    = al_be;
    end
    if (merge) begin
      ent_d[tail_m1].data = merged_data;
      ent_d[tail_m1].be   = ent_q[tail_m1].be | al_be;
    end
  end

  always_comb begin
    head_d     = pop  ? head_q + PW'(1) : head_q;
    tail_d     = push ? tail_q + PW'(1) : tail_q;
    count_d    = count_q + (PW+1)'(push) - (PW+1)'(pop);
    misalign_d = accept && !al_ill && al_mis;
  end

  always_comb begin
    logic [PW-1:0] off;
    ld_hit = 1'b0;
    off    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - head_q;
      if (({1'b0, off} < count_q) && (ent_q[i].waddr == ld_addr[31:2])) ld_hit = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      misalign_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      misalign_q <= misalign_d;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
    end
  end

endmodule

// File: tb/tb_mem_store_buffer.sv
// Scoreboard bench for mem_store_buffer: a queue-based model predicts every
// memory write, checked by an independent monitor on each accepted drain.
module tb_mem_store_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        st_valid = 1'b0;
  logic        st_ready;
  logic [2:0]  st_op = 3'd0;
  logic [31:0] st_addr = 32'h0;
  logic [31:0] st_data = 32'h0;
  logic        misalign;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [31:0] ld_addr = 32'h0;
  logic        ld_hit;
  logic        empty;

  mem_store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .st_valid(st_valid), .st_ready(st_ready), .st_op(st_op),
    .st_addr(st_addr), .st_data(st_data), .misalign(misalign), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack),
    .ld_addr(ld_addr), .ld_hit(ld_hit), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [29:0] w;
    logic [31:0] d;
    logic [3:0]  be;
  } ment_t;

  ment_t mbuf[$];
  ment_t expq[$];
  bit    exp_mis = 0;
  int    errors = 0;
  int    checks = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference byte-lane placement computed with plain arithmetic.
  task automatic align(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d,
                       output logic [3:0] be, output logic [31:0] dd, output bit mis, output bit ill);
    int lo;
    lo = int'(a % 4);
    be = 0; dd = 0; mis = 0; ill = 0;
    case (op)
      3'd0: begin be = 4'hF; dd = d; mis = (lo != 0); end
      3'd1: begin be = (lo >= 2) ? 4'hC : 4'h3; dd = (d & 32'hFFFF) * 32'h0001_0001; mis = (lo % 2) == 1; end
      3'd2: begin be = 4'(1 << lo); dd = (d & 32'hFF) * 32'h0101_0101; end
      default: ill = 1;
    endcase
  endtask

  function automatic bit model_hit(input logic [31:0] la);
    foreach (mbuf[i]) if (mbuf[i].w == la[31:2]) return 1;
    return 0;
  endfunction

  task automatic cycle(input bit v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] d,
                       input bit ack, input logic [31:0] la);
    bit acc, popping, mis, ill;
    logic [3:0] be;
    logic [31:0] dd;
    int n;
    @(negedge clk);
    st_valid = v; st_op = op; st_addr = a; st_data = d; mem_ack = ack; ld_addr = la;
    #1;
    chk("st_ready", 32'(st_ready), 32'(mbuf.size() < DEPTH));
    chk("mem_req", 32'(mem_req), 32'(mbuf.size() > 0));
    chk("empty", 32'(empty), 32'(mbuf.size() == 0));
    chk("misalign", 32'(misalign), 32'(exp_mis));
    chk("ld_hit", 32'(ld_hit), 32'(model_hit(la)));
    acc     = v && (mbuf.size() < DEPTH);
    popping = ack && (mbuf.size() > 0);
    exp_mis = 0;
    if (acc) begin
      align(op, a, d, be, dd, mis, ill);
      if (!ill && mis) exp_mis = 1;
      else if (!ill) begin
        n = mbuf.size();
        if (n >= 2 && mbuf[n-1].w == a[31:2]) begin
          for (int b = 0; b < 4; b++)
            if (be[b]) mbuf[n-1].d[8*b +: 8] = dd[8*b +: 8];
          mbuf[n-1].be = mbuf[n-1].be | be;
        end else begin
          mbuf.push_back('{w: a[31:2], d: dd, be: be});
        end
      end
    end
    if (popping) expq.push_back(mbuf.pop_front());
  endtask

  task automatic idle(input bit ack, input logic [31:0] la);
    cycle(0, 3'd0, 32'h0, 32'h0, ack, la);
  endtask

  // Monitor: every accepted drain must match the next predicted write.
  initial begin
    ment_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && mem_req && mem_ack) begin
        if (expq.size() == 0) begin
          checks++; errors++;
          $display("FAIL stray_write: addr 0x%08h be %b with no write expected", mem_addr, mem_be);
        end else begin
          e = expq.pop_front();
          chk("wr_addr", mem_addr, {e.w, 2'b00});
          chk("wr_data", mem_wdata, e.d);
          chk("wr_be", 32'(mem_be), 32'(e.be));
        end
      end
    end
  end

  initial begin
    logic [31:0] a, la;
    logic [2:0]  op;
    int r;
    #3;
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_be", 32'(mem_be), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_st_ready", 32'(st_ready), 1);
    chk("rst_misalign", 32'(misalign), 0);
    chk("rst_ld_hit", 32'(ld_hit), 0);
    @(negedge clk); rst = 0;

    // SB into empty buffer -> request next cycle
    cycle(1, 3'd2, 32'h1003, 32'hAB, 0, 32'h0);
    idle(0, 32'h0);
    chk("sb_addr", mem_addr, 32'h1000);
    chk("sb_be", 32'(mem_be), 32'b1000);
    chk("sb_wdata", mem_wdata, 32'hABABABAB);
    idle(1, 32'h0);

    cycle(1, 3'd1, 32'h2002, 32'h1234, 0, 32'h0);
    idle(0, 32'h0);
    chk("sh_be", 32'(mem_be), 32'b1100);
    chk("sh_wdata", mem_wdata, 32'h12341234);
    idle(1, 32'h0);
    cycle(1, 3'd1, 32'h2001, 32'h5555, 0, 32'h0);
    idle(0, 32'h0);
    chk("sh_mis_pulse", 32'(misalign), 1);
    chk("sh_mis_empty", 32'(empty), 1);
    cycle(1, 3'd5, 32'h2000, 32'h1, 0, 32'h0);
    idle(0, 32'h0);
    chk("illegal_no_mis", 32'(misalign), 0);

    // Fill to capacity with ack low
    for (int i = 0; i < 4; i++) cycle(1, 3'd0, 32'h6000 + 32'(i) * 16, 32'hC0DE0000 + 32'(i), 0, 32'h0);
    idle(0, 32'h0);
    chk("full_not_ready", 32'(st_ready), 0);
    cycle(1, 3'd0, 32'h7000, 32'hDEAD, 1, 32'h0);
    idle(0, 32'h0);
    chk("ready_after_ack", 32'(st_ready), 1);
    chk("head_advanced", mem_addr, 32'h6010);
    repeat (4) idle(1, 32'h0);

    // Merge behind a busy head
    cycle(1, 3'd0, 32'h5000, 32'hFFFF0000, 0, 32'h0);
    cycle(1, 3'd2, 32'h3000, 32'h11, 0, 32'h0);
    cycle(1, 3'd2, 32'h3001, 32'h22, 0, 32'h0);
    idle(0, 32'h3002);
    chk("ld_hit_buffered", 32'(ld_hit), 1);
    idle(1, 32'h3002);
    idle(0, 32'h3002);
    chk("merge_be", 32'(mem_be), 32'b0011);
    chk("merge_lo", mem_wdata & 32'hFFFF, 32'h2211);
    idle(1, 32'h3002);
    idle(0, 32'h3002);
    chk("ld_hit_cleared", 32'(ld_hit), 0);

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      a  = 32'h4000 + 32'($urandom_range(0, 5)) * 4 + 32'($urandom_range(0, 3));
      la = 32'h4000 + 32'($urandom_range(0, 6)) * 4 + 32'($urandom_range(0, 3));
      r  = $urandom_range(0, 9);
      op = (r < 3) ? 3'd0 : (r < 6) ? 3'd1 : (r < 9) ? 3'd2 : 3'($urandom_range(3, 7));
      if (op == 3'd0 && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      cycle($urandom_range(0, 2) != 0, op, a, $urandom, $urandom_range(0, 2) == 0, la);
    end
    repeat (8) idle(1, 32'h0);

    // Async reset mid-drain
    repeat (2) idle(1, 32'h0);
    for (int i = 0; i < 3; i++) cycle(1, 3'd0, 32'h8000 + 32'(i) * 4, 32'h100 + 32'(i), 0, 32'h0);
    idle(0, 32'h0);
    chk("pre_rst_req", 32'(mem_req), 1);
    @(negedge clk);
    st_valid = 0; mem_ack = 1; rst = 1;
    #1;
    chk("mid_rst_req", 32'(mem_req), 0);
    chk("mid_rst_empty", 32'(empty), 1);
    chk("mid_rst_addr", mem_addr, 0);
    chk("mid_rst_be", 32'(mem_be), 0);
    mbuf.delete(); expq.delete(); exp_mis = 0;
    @(negedge clk); rst = 0;
    repeat (6) idle(1, 32'h8000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
